// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Byte-access build option: LSU_BYTE_ACCESS_EN.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    localparam int LSU_MEM_WORDS_DEFAULT = 1024;
    localparam int LSU_LANE_W            = 2;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte lane extract/merge helpers for a little-endian 32-bit word.
// Lane 0 is bits [7:0]. Instantiated only when LSU_BYTE_ACCESS_EN is defined.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0]           word_i,
    input  logic [LSU_LANE_W-1:0] lane_i,
    input  logic [7:0]            byte_i,
    output logic [31:0]           ext_o,
    output logic [31:0]           merged_o
);

    // Pick the addressed lane (zero-extended) and build the word with that lane replaced
    always_comb begin
        ext_o    = 32'h0;
        merged_o = word_i;
        case (lane_i)
            2'd0: begin
                ext_o[7:0]      = word_i[7:0];
                merged_o[7:0]   = byte_i;
            end
            2'd1: begin
                ext_o[7:0]      = word_i[15:8];
                merged_o[15:8]  = byte_i;
            end
            2'd2: begin
                ext_o[7:0]      = word_i[23:16];
                merged_o[23:16] = byte_i;
            end
            default: begin
                ext_o[7:0]      = word_i[31:24];
                merged_o[31:24] = byte_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of a single-port registered word memory.
// Byte loads/stores (read-modify-write) are built only when LSU_BYTE_ACCESS_EN
// is defined; otherwise req_byte is ignored and every access is a word access.
//
// state | meaning
// IDLE  | ready for a request
// READ  | memory read cycle (loads, and first half of a byte store)
// WRITE | single memory write cycle
// RESP  | response presented until resp_ready
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = LSU_MEM_WORDS_DEFAULT,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic             req_byte,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_write,
    output logic             resp_fault,

    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data_in,
    output logic             mem_enable,
    output logic             mem_read_not_write,
    input  logic [31:0]      mem_data_out
);

    lsu_state_e       state_q, state_d;
    logic [29:0]      idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             write_q, write_d;
    logic             fault_q, fault_d;

    logic             req_is_byte;
    logic             req_fault;
    logic [31:0]      wr_word;
    logic [31:0]      rd_word;

`ifdef LSU_BYTE_ACCESS_EN
    logic                  byte_q, byte_d;
    logic [LSU_LANE_W-1:0] lane_q, lane_d;
    logic [31:0]           lane_ext;
    logic [31:0]           lane_merged;

    lsu_byte_lane u_byte_lane (
        .word_i   (mem_data_out),
        .lane_i   (lane_q),
        .byte_i   (wdata_q[7:0]),
        .ext_o    (lane_ext),
        .merged_o (lane_merged)
    );

    assign req_is_byte = req_byte;
    assign wr_word     = byte_q ? lane_merged : wdata_q;
    assign rd_word     = byte_q ? lane_ext : mem_data_out;
`else
    logic unused_req_byte;

    assign unused_req_byte = req_byte;
    assign req_is_byte     = 1'b0;
    assign wr_word         = wdata_q;
    assign rd_word         = mem_data_out;
`endif

    // Byte accesses may sit on any lane; word accesses must be aligned, and
    // the word index must fall inside the memory.
    assign req_fault = (!req_is_byte && (req_addr[1:0] != 2'b00))
                     || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

    // State and request-field registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wdata_q <= '0;
            tag_q   <= '0;
            write_q <= 1'b0;
            fault_q <= 1'b0;
`ifdef LSU_BYTE_ACCESS_EN
            byte_q  <= 1'b0;
            lane_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            tag_q   <= tag_d;
            write_q <= write_d;
            fault_q <= fault_d;
`ifdef LSU_BYTE_ACCESS_EN
            byte_q  <= byte_d;
            lane_q  <= lane_d;
`endif
        end
    end

    // Next-state and request capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        tag_d   = tag_q;
        write_d = write_q;
        fault_d = fault_q;
`ifdef LSU_BYTE_ACCESS_EN
        byte_d  = byte_q;
        lane_d  = lane_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d   = req_addr[31:2];
                    wdata_d = req_wdata;
                    tag_d   = req_tag;
                    write_d = req_write;
                    fault_d = req_fault;
`ifdef LSU_BYTE_ACCESS_EN
                    byte_d  = req_byte;
                    lane_d  = req_addr[1:0];
`endif
                    if (req_fault) begin
                        state_d = RESP;
                    end else if (req_write && !req_is_byte) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
`ifdef LSU_BYTE_ACCESS_EN
                state_d = write_q ? WRITE : RESP;
`else
                state_d = RESP;
`endif
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake, memory and response outputs decoded from the current state
    always_comb begin
        req_ready          = 1'b0;
        resp_valid         = 1'b0;
        resp_rdata         = 32'h0;
        resp_fault         = 1'b0;
        mem_addr           = 32'h0;
        mem_data_in        = 32'h0;
        mem_enable         = 1'b0;
        mem_read_not_write = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready = !reset;
            end
            READ: begin
                mem_enable = 1'b1;
                mem_addr   = {2'b00, idx_q};
            end
            WRITE: begin
                mem_addr           = {2'b00, idx_q};
                mem_data_in        = wr_word;
                // A reset landing in this cycle must not let the write through.
                mem_read_not_write = reset;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                if (!fault_q && !write_q) begin
                    resp_rdata = rd_word;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign resp_tag   = tag_q;
    assign resp_write = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural registered word memory.
// Expectations follow LSU_BYTE_ACCESS_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_tag = 4'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_tag;
    logic        resp_write;
    logic        resp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_in;
    logic        mem_enable;
    logic        mem_read_not_write;
    logic [31:0] mem_data_out = 32'h0;

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    logic [31:0] wr_data = 32'h0;
    int          n_vec = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(1024), .TAG_W(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_byte           (req_byte),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_tag            (req_tag),
        .resp_valid         (resp_valid),
        .resp_ready         (resp_ready),
        .resp_rdata         (resp_rdata),
        .resp_tag           (resp_tag),
        .resp_write         (resp_write),
        .resp_fault         (resp_fault),
        .mem_addr           (mem_addr),
        .mem_data_in        (mem_data_in),
        .mem_enable         (mem_enable),
        .mem_read_not_write (mem_read_not_write),
        .mem_data_out       (mem_data_out)
    );

    // Registered-read single-port memory; output holds when not enabled
    always @(posedge clk) begin
        if (mem_enable) mem_data_out <= mem[mem_addr[9:0]];
        if (!mem_read_not_write) mem[mem_addr[9:0]] <= mem_data_in;
    end

    // Count every write edge and remember the data written
    always @(posedge clk) begin
        if (!mem_read_not_write) begin
            wr_cnt  <= wr_cnt + 1;
            wr_data <= mem_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic w, input logic b, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] t,
                          output int lat, output logic [31:0] rd,
                          output logic flt, output logic [3:0] rt, output logic rw);
        @(negedge clk);
        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_write = w;
        req_byte  = b;
        req_addr  = a;
        req_wdata = wd;
        req_tag   = t;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        rd  = resp_rdata;
        flt = resp_fault;
        rt  = resp_tag;
        rw  = resp_write;
        @(posedge clk);
        #1;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        flt;
    logic [3:0]  rt;
    logic        rw;
    int          w0;
    logic [31:0] hold_rd;
    logic [3:0]  hold_tag;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_fault", {31'h0, resp_fault}, 32'h0);
        chk("rst_mem_enable", {31'h0, mem_enable}, 32'h0);
        chk("rst_mem_rnw", {31'h0, mem_read_not_write}, 32'h1);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("req_ready_after_rst", {31'h0, req_ready}, 32'h1);

        // Word store then word load
        w0 = wr_cnt;
        do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'h3, lat, rd, flt, rt, rw);
        chk("str_lat", lat, 2);
        chk("str_rdata", rd, 32'h0);
        chk("str_fault", {31'h0, flt}, 32'h0);
        chk("str_tag", {28'h0, rt}, 32'h3);
        chk("str_write", {31'h0, rw}, 32'h1);
        chk("str_wr_cnt", wr_cnt - w0, 1);
        chk("str_mem", mem[4], 32'hDEADBEEF);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h5, lat, rd, flt, rt, rw);
        chk("ldr_lat", lat, 2);
        chk("ldr_rdata", rd, 32'hDEADBEEF);
        chk("ldr_tag", {28'h0, rt}, 32'h5);
        chk("ldr_write", {31'h0, rw}, 32'h0);

        // Byte store merge (or word-only fallback)
        do_req(1'b1, 1'b0, 32'h20, 32'h11223344, 4'h1, lat, rd, flt, rt, rw);
        chk("pre_mem", mem[8], 32'h11223344);
        w0 = wr_cnt;
        do_req(1'b1, 1'b1, 32'h22, 32'h000000AA, 4'h2, lat, rd, flt, rt, rw);
`ifdef LSU_BYTE_ACCESS_EN
        chk("strb_lat", lat, 3);
        chk("strb_fault", {31'h0, flt}, 32'h0);
        chk("strb_wr_cnt", wr_cnt - w0, 1);
        chk("strb_wr_data", wr_data, 32'h11AA3344);
        chk("strb_mem", mem[8], 32'h11AA3344);
        do_req(1'b0, 1'b1, 32'h22, 32'h0, 4'h6, lat, rd, flt, rt, rw);
        chk("ldrb_lat", lat, 2);
        chk("ldrb_rdata", rd, 32'h000000AA);
        w0 = wr_cnt;
        do_req(1'b1, 1'b1, 32'h20, 32'h000000AA, 4'h2, lat, rd, flt, rt, rw);
        chk("strb0_wr_cnt", wr_cnt - w0, 1);
        chk("strb0_mem", mem[8], 32'h11AA33AA);
`else
        chk("strb_fault", {31'h0, flt}, 32'h1);
        chk("strb_lat", lat, 1);
        chk("strb_rdata", rd, 32'h0);
        chk("strb_wr_cnt", wr_cnt - w0, 0);
        chk("strb_mem", mem[8], 32'h11223344);
        w0 = wr_cnt;
        do_req(1'b1, 1'b1, 32'h20, 32'h000000AA, 4'h2, lat, rd, flt, rt, rw);
        chk("strb0_lat", lat, 2);
        chk("strb0_fault", {31'h0, flt}, 32'h0);
        chk("strb0_wr_cnt", wr_cnt - w0, 1);
        chk("strb0_mem", mem[8], 32'h000000AA);
`endif

        // Faults: misaligned word, out of range; last valid word does not fault
        w0 = wr_cnt;
        do_req(1'b0, 1'b0, 32'h13, 32'h0, 4'h4, lat, rd, flt, rt, rw);
        chk("mis_fault", {31'h0, flt}, 32'h1);
        chk("mis_rdata", rd, 32'h0);
        chk("mis_lat", lat, 1);
        chk("mis_tag", {28'h0, rt}, 32'h4);
        do_req(1'b0, 1'b0, 32'h1000, 32'h0, 4'h8, lat, rd, flt, rt, rw);
        chk("oor_fault", {31'h0, flt}, 32'h1);
        chk("oor_rdata", rd, 32'h0);
        chk("oor_lat", lat, 1);
        do_req(1'b1, 1'b0, 32'h1000, 32'h5555AAAA, 4'h8, lat, rd, flt, rt, rw);
        chk("oor_st_fault", {31'h0, flt}, 32'h1);
        chk("fault_no_write", wr_cnt - w0, 0);
        do_req(1'b0, 1'b0, 32'hFFC, 32'h0, 4'h9, lat, rd, flt, rt, rw);
        chk("top_fault", {31'h0, flt}, 32'h0);
        chk("top_lat", lat, 2);

        // Back-pressure: response held stable, no new accept
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_byte   = 1'b0;
        req_addr   = 32'h10;
        req_tag    = 4'h7;
        @(posedge clk);
        #1 req_addr = 32'h20;
        req_tag = 4'hA;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        chk("bp_lat", lat, 2);
        hold_rd  = resp_rdata;
        hold_tag = resp_tag;
        chk("bp_rdata", hold_rd, 32'hDEADBEEF);
        chk("bp_tag", {28'h0, hold_tag}, 32'h7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_rdata_hold", resp_rdata, hold_rd);
            chk("bp_tag_hold", {28'h0, resp_tag}, {28'h0, hold_tag});
            chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_done_valid", {31'h0, resp_valid}, 32'h0);
        chk("bp_done_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        chk("bp_next_lat", lat, 2);
        chk("bp_next_tag", {28'h0, resp_tag}, 32'hA);
        @(posedge clk);
        #1;

        // Reset during the WRITE cycle of a word store
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_tag   = 4'hB;
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_rnw", {31'h0, mem_read_not_write}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstw_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rstw_req_ready", {31'h0, req_ready}, 32'h1);
        repeat (2) @(negedge clk);
        chk("rstw_idle_valid", {31'h0, resp_valid}, 32'h0);
        chk("rstw_wr_cnt", wr_cnt - w0, 0);
        chk("rstw_mem", mem[12], 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
